// File: rtl/mult8x8_seq.sv
// Sequential 8x8 unsigned multiplier: one 4x4 core reused over four cycles,
// one nibble partial product per cycle, with a start/done/busy handshake.

module mult4x4 (
  input  logic [3:0] dataa,
  input  logic [3:0] datab,
  output logic [7:0] product
);

  assign product = {4'b0000, dataa} * {4'b0000, datab};

endmodule

module mult8x8_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  dataa,
  input  logic [7:0]  datab,
  output logic [15:0] product,
  output logic        done,
  output logic        busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state, state_next;
  logic [1:0]  step, step_next;
  logic [15:0] acc, acc_next;
  logic [7:0]  a_r, a_next;
  logic [7:0]  b_r, b_next;
  logic [15:0] product_next;
  logic        done_next;
  logic        busy_next;

  logic [3:0]  core_a;
  logic [3:0]  core_b;
  logic [7:0]  pp;
  logic [15:0] pp_shifted;
  logic [15:0] sum;

  // step[0] picks the high multiplicand nibble, step[1] the high multiplier nibble
  assign core_a = step[0] ? a_r[7:4] : a_r[3:0];
  assign core_b = step[1] ? b_r[7:4] : b_r[3:0];

  mult4x4 u_core (
    .dataa   (core_a),
    .datab   (core_b),
    .product (pp)
  );

  always_comb begin
    pp_shifted = {8'h00, pp};
    case (step)
      2'd0:    pp_shifted = {8'h00, pp};
      2'd1,
      2'd2:    pp_shifted = {4'h0, pp, 4'h0};
      default: pp_shifted = {pp, 8'h00};
    endcase
  end

  assign sum = acc + pp_shifted;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      step    <= 2'd0;
      acc     <= 16'h0000;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      product <= 16'h0000;
      done    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      step    <= step_next;
      acc     <= acc_next;
      a_r     <= a_next;
      b_r     <= b_next;
      product <= product_next;
      done    <= done_next;
      busy    <= busy_next;
    end
  end

  // done is a one-cycle pulse, so it defaults low and is only raised on the last step
  always_comb begin
    state_next   = state;
    step_next    = step;
    acc_next     = acc;
    a_next       = a_r;
    b_next       = b_r;
    product_next = product;
    done_next    = 1'b0;
    busy_next    = busy;

    case (state)
      IDLE: begin
        if (start) begin
          a_next     = dataa;
          b_next     = datab;
          acc_next   = 16'h0000;
          step_next  = 2'd0;
          busy_next  = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        acc_next = sum;
        if (step == 2'd3) begin
          product_next = sum;
          done_next    = 1'b1;
          busy_next    = 1'b0;
          step_next    = 2'd0;
          state_next   = IDLE;
        end else begin
          step_next = step + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mult8x8_seq.sv
// Self-checking bench for mult8x8_seq: table-driven single operations plus
// hand-written sequences for back-to-back, busy-ignore, operand change and reset abort.

module tb_mult8x8_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  dataa;
  logic [7:0]  datab;
  logic [15:0] product;
  logic        done;
  logic        busy;

  int checks;
  int failures;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vec_t;

  vec_t vecs[9];

  mult8x8_seq dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .dataa   (dataa),
    .datab   (datab),
    .product (product),
    .done    (done),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h", name, actual, expected);
    end
  endtask

  // One full operation with start pulsed for the accept edge only
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic [15:0] expected);
    dataa = a;
    datab = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy after accept", 16'(busy), 16'h0001);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput("done early", 16'(done), 16'h0000);
    end
    tick();
    checkOutput("done at E+4", 16'(done), 16'h0001);
    checkOutput("product", product, expected);
    checkOutput("busy at E+4", 16'(busy), 16'h0000);
    tick();
    checkOutput("done one cycle", 16'(done), 16'h0000);
    checkOutput("product hold", product, expected);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dataa    = 8'h00;
    datab    = 8'h00;

    vecs[0] = '{8'h00, 8'h02, 16'h0000};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h12, 8'h34, 16'h03A8};
    vecs[3] = '{8'h01, 8'h01, 16'h0001};
    vecs[4] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[5] = '{8'h10, 8'h10, 16'h0100};
    vecs[6] = '{8'hF0, 8'h0F, 16'h0E10};
    vecs[7] = '{8'hAB, 8'hCD, 16'h88EF};
    vecs[8] = '{8'h80, 8'hFF, 16'h7F80};

    #3;
    checkOutput("reset product", product, 16'h0000);
    checkOutput("reset done", 16'(done), 16'h0000);
    checkOutput("reset busy", 16'(busy), 16'h0000);
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] table vectors");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].expected);
    end

    // Asynchronous reset between edges must clear outputs without waiting for a clock
    $display("[TB] async reset");
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset product", product, 16'h0000);
    checkOutput("async reset done", 16'(done), 16'h0000);
    checkOutput("async reset busy", 16'(busy), 16'h0000);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("idle product", product, 16'h0000);
      checkOutput("idle busy", 16'(busy), 16'h0000);
      checkOutput("idle done", 16'(done), 16'h0000);
    end

    $display("[TB] back-to-back sweep");
    start = 1'b1;
    datab = 8'h02;
    for (int i = 0; i < 100; i++) begin
      logic [7:0] av;
      av = 8'((i * 3) % 256);
      dataa = av;
      tick();
      checkOutput("sweep busy", 16'(busy), 16'h0001);
      dataa = ~av;
      repeat (3) tick();
      tick();
      checkOutput("sweep done", 16'(done), 16'h0001);
      checkOutput("sweep product", product, {7'b0, av, 1'b0});
    end
    start = 1'b0;
    tick();
    checkOutput("sweep end busy", 16'(busy), 16'h0000);
    checkOutput("sweep end done", 16'(done), 16'h0000);
    tick();

    $display("[TB] start ignored while busy");
    dataa = 8'h0F;
    datab = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    dataa = 8'hFF;
    datab = 8'hFF;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checkOutput("ignore done", 16'(done), 16'h0001);
    checkOutput("ignore product", product, 16'h00F0);
    tick();
    checkOutput("ignore busy E+5", 16'(busy), 16'h0000);
    checkOutput("ignore done E+5", 16'(done), 16'h0000);
    tick();
    checkOutput("ignore no second done", 16'(done), 16'h0000);
    checkOutput("ignore product hold", product, 16'h00F0);

    $display("[TB] operand stability");
    dataa = 8'hA5;
    datab = 8'h3C;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      dataa = 8'($urandom_range(0, 255));
      datab = 8'($urandom_range(0, 255));
      tick();
    end
    checkOutput("stability done", 16'(done), 16'h0001);
    checkOutput("stability product", product, 16'h26AC);
    tick();

    $display("[TB] reset mid-operation");
    dataa = 8'h80;
    datab = 8'h80;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midop reset product", product, 16'h0000);
    checkOutput("midop reset busy", 16'(busy), 16'h0000);
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checkOutput("midop no done", 16'(done), 16'h0000);
      checkOutput("midop busy", 16'(busy), 16'h0000);
      checkOutput("midop product", product, 16'h0000);
    end
    applyStimulus(8'h80, 8'h80, 16'h4000);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult8x8_seq.md
# mult8x8_seq

Sequential 8x8 unsigned multiplier. It time-multiplexes one `mult4x4` combinational core across four cycles, one per nibble partial product. A shift-and-accumulate register and a small FSM combine the results into a 16-bit product. It is the area-reduced alternative to the four-instance parallel 8x8 multiplier and uses a start/done handshake toward its host.

## Interface
- No parameters; widths fixed: operands 8 bits, product 16 bits, internal core `mult4x4` with 4-bit `dataa`/`datab` and 8-bit `product`.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  request; sampled only in IDLE.
- dataa  in  8  multiplicand; sampled on the accepting edge only.
- datab  in  8  multiplier; sampled on the accepting edge only.
- product  out  16  registered result; holds until overwritten by the next completed operation.
- done  out  1  registered one-cycle pulse; marks `product` newly valid.
- busy  out  1  registered; high while an operation is in progress.

## Operation
- States: IDLE, RUN. A 2-bit step counter `step` (0..3) is valid in RUN.
- IDLE with start=1 at an edge (the accept edge):
  - latch `a_r<=dataa` and `b_r<=datab`;
  - set acc<=0, step<=0, busy<=1, state<=RUN.
- IDLE with start=0: no change, except done returns to 0.
- Core input mux in RUN, driven by `step`:
  - 0: a_r[3:0] x b_r[3:0], shift 0;
  - 1: a_r[7:4] x b_r[3:0], shift 4;
  - 2: a_r[3:0] x b_r[7:4], shift 4;
  - 3: a_r[7:4] x b_r[7:4], shift 8.
- Each RUN edge: acc <= acc + (pp << shift), where pp is the 8-bit core output zero-extended to 16 bits.
- Step 0..2: step increments, state stays in RUN.
- Step 3 edge:
  - product <= acc + (pp << 8);
  - done<=1, busy<=0, state<=IDLE.
- Width rule: the 16-bit accumulator never overflows. Maximum result is 255x255 = 0xFE01. All arithmetic is unsigned.
- start while in RUN is ignored; operands are not re-latched and there is no queuing.
- start held high continuously: a new operation is accepted at every IDLE edge, giving back-to-back operations.
- done clears on the edge after it is set, regardless of start.
- The `product` register changes only on a step-3 edge or on reset. The intermediate accumulator is never visible on `product`.

## Timing
- Reset values: product=0x0000, done=0, busy=0, state=IDLE, step=0, acc=0, a_r=b_r=0.
- Reset asserted mid-operation: the operation is aborted with no done pulse, and the block sits in IDLE after release.
- Accept at edge E:
  - busy high after E;
  - accumulate edges E+1..E+4;
  - product and done valid after edge E+4;
  - busy low after edge E+4.
- Latency: 4 clocks from the accept edge to the done edge.
- Throughput: the earliest next accept is edge E+5, during the done cycle. That gives 5 clocks per operation.
- dataa/datab may change freely after the accept edge without affecting the result.
- The core is purely combinational between the operand registers and acc. The path is mux, 4x4 multiply, 16-bit add, all within one clock.

## Test plan
- Reset:
  - Stimulus: assert reset mid-cycle with no clock edge.
  - Required response: product=0x0000, done=0 and busy=0 immediately; start=0 afterward keeps all outputs static.
- Corner operands: 0x00x0x02 -> 0x0000; 0xFFx0xFF -> 0xFE01; 0x12x0x34 -> 0x03A8.
  - Each checked exactly 4 clocks after accept.
  - done is high for exactly one cycle.
- Sweep:
  - Stimulus: datab=0x02, dataa starting at 0 and incremented by 3 per operation, wrapping mod 256, for 100 operations.
  - Required response: every product equals 2xdataa.
  - Back-to-back with start held high; operations accepted every 5 clocks.
- Busy ignore:
  - Stimulus: accept 0x0Fx0x10, then pulse start with 0xFFx0xFF at E+2.
  - Required response: product=0x00F0 at E+4, no second done pulse, busy low at E+5.
- Operand stability:
  - Stimulus: accept 0xA5x0x3C, then change dataa/datab every cycle during RUN.
  - Required response: product=0x26AC.
- Reset mid-op:
  - Stimulus: accept 0x80x0x80, assert reset between E+2 and E+3, then release.
  - Required response: no done pulse; product=0x0000; busy=0; the next accept of 0x80x0x80 yields 0x4000.
